// File: rtl/tft_pkg.sv
// Shared definitions for the TFT display path.
//   - RGB565 colour constants (shared with the image generator)
//   - FSM state encoding for the stream reader
//   - Default 480x272 panel timing
package tft_pkg;

  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] WHITE   = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BACK   = 2;
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FRONT  = 2;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BACK   = 2;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FRONT  = 2;

endpackage

// File: rtl/tft_stream_reader_timing.sv
// tft_timing_gen: free-running TFT raster counters with raw decode.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   hs_raw        low while h_cnt < H_SYNC
//   vs_raw        low while v_cnt < V_SYNC
//   active        inside the visible window
//   frame_start   h_cnt == 0 and v_cnt == 0
//   frame_end     h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1
//   last_pixel    last visible column of the last visible line
module tft_timing_gen
  import tft_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
  input  logic clk,
  input  logic rst,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic frame_start,
  output logic frame_end,
  output logic last_pixel
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  // Inclusive bounds keep every constant representable in the counter width.
  localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_SYNC_END  = H_W'(H_SYNC);
  localparam logic [V_W-1:0] V_SYNC_END  = V_W'(V_SYNC);
  localparam logic [H_W-1:0] H_ACT_FIRST = H_W'(H_SYNC + H_BACK);
  localparam logic [H_W-1:0] H_ACT_LAST  = H_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_ACT_FIRST = V_W'(V_SYNC + V_BACK);
  localparam logic [V_W-1:0] V_ACT_LAST  = V_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    hs_raw      = (h_cnt >= H_SYNC_END);
    vs_raw      = (v_cnt >= V_SYNC_END);
    active      = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST) &&
                  (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    last_pixel  = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  end

endmodule

// File: rtl/tft_stream_reader.sv
// tft_stream_reader: reads RGB565 pixels from the frame-buffer read FIFO
// and drives a TFT panel with registered hsync/vsync/de/rgb.
// Optional build macro: TFT_UNDERFLOW_CNT_EN adds underflow_cnt[15:0].
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   data_en       buffer holds valid image data (level)
//   fifo_empty    read FIFO empty flag
//   data_in       FIFO read data, valid the cycle after data_req
//   data_req      FIFO read strobe
//   tft_hs/vs     active-low syncs, tft_de active-high, tft_rgb pixel
//   frame_done    pulse after the last active pixel of an enabled frame
//   underflow     sticky: a request met an empty FIFO
module tft_stream_reader
  import tft_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic        fifo_empty,
  input  logic [15:0] data_in,
  output logic        data_req,
  output logic        tft_hs,
  output logic        tft_vs,
  output logic        tft_de,
  output logic [15:0] tft_rgb,
  output logic        frame_done,
  output logic        underflow
`ifdef TFT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  state_t state, state_next;

  logic hs_raw, vs_raw, active, frame_start, frame_end, last_pixel;
  logic req_d1, req_d2, empty_d1;
  logic hs_d1, vs_d1;
  logic last_d1, last_d2;

  tft_timing_gen #(
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .last_pixel  (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Frames only start and stop on the raster wrap; data_en is ignored mid-frame.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (data_en && frame_start) state_next = RUN;
      RUN:  if (frame_end && !data_en)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_req = (state == RUN) && active;
  end

  // Two-stage panel pipeline: stage 1 waits for FIFO read data, stage 2 drives pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d1     <= 1'b0;
      req_d2     <= 1'b0;
      empty_d1   <= 1'b0;
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b1;
      last_d1    <= 1'b0;
      last_d2    <= 1'b0;
      tft_hs     <= 1'b1;
      tft_vs     <= 1'b1;
      tft_rgb    <= BLACK;
      frame_done <= 1'b0;
    end else begin
      req_d1     <= data_req;
      req_d2     <= req_d1;
      empty_d1   <= fifo_empty;
      hs_d1      <= hs_raw;
      vs_d1      <= vs_raw;
      last_d1    <= data_req && last_pixel;
      last_d2    <= last_d1;
      tft_hs     <= hs_d1;
      tft_vs     <= vs_d1;
      tft_rgb    <= (req_d1 && !empty_d1) ? data_in : BLACK;
      frame_done <= last_d2;
    end
  end

  always_comb begin
    tft_de = req_d2;
  end

  always_ff @(posedge clk) begin
    if (rst)                          underflow <= 1'b0;
    else if (data_req && fifo_empty)  underflow <= 1'b1;
  end

`ifdef TFT_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      underflow_cnt <= '0;
    else if (data_req && fifo_empty && (underflow_cnt != 16'hFFFF))
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule
